// File: rtl/puf_uart_framer.sv
// Frames a PUF response as [SYNC, data bytes MSB-first, XOR checksum]; SYNC appears the cycle after the request edge.
// Valid/ready producer: each byte is held until accepted, with a one-cycle gap after every accept.
module puf_uart_framer #(
    parameter int          RESP_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RESP_WIDTH-1:0] resp_data,
    input  logic                  resp_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            drop_count
);
    localparam int NBYTES = RESP_WIDTH / 8;
    localparam int IW     = $clog2(NBYTES + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rv_q;
    logic                  r_armed;
    logic [RESP_WIDTH-1:0] r_shift;
    logic [7:0]            r_csum;
    logic [IW-1:0]         r_idx;
    logic [7:0]            r_drop;

    logic                  w_edge;
    logic                  w_accept;
    logic                  w_is_data;
    logic [7:0]            w_data_byte;

    // r_armed masks the first cycle after reset so a level already high at release is not an edge
    assign w_edge      = resp_valid & ~r_rv_q & r_armed;
    assign w_accept    = (r_state == S_SEND) & tx_ready;
    assign w_is_data   = (r_idx != '0) && (r_idx != LAST_IDX);
    assign w_data_byte = r_shift[RESP_WIDTH-1 -: 8];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_edge) w_next = S_SEND;
            S_SEND: if (w_accept) w_next = (r_idx == LAST_IDX) ? S_DONE : S_GAP;
            S_GAP:  w_next = S_SEND;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv_q  <= 1'b0;
            r_armed <= 1'b0;
            r_shift <= '0;
            r_csum  <= 8'h00;
            r_idx   <= '0;
            r_drop  <= 8'h00;
        end else begin
            r_rv_q  <= resp_valid;
            r_armed <= 1'b1;
            if ((r_state == S_IDLE) && w_edge) begin
                r_shift <= resp_data;
                r_csum  <= 8'h00;
                r_idx   <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + IW'(1);
                if (w_is_data) begin
                    r_csum  <= r_csum ^ w_data_byte;
                    r_shift <= r_shift << 8;
                end
            end
            if (w_edge && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    always_comb begin
        tx_data = 8'h00;
        if (r_state == S_SEND) begin
            if (r_idx == '0) begin
                tx_data = SYNC_BYTE;
            end else if (r_idx == LAST_IDX) begin
                tx_data = r_csum;
            end else begin
                tx_data = w_data_byte;
            end
        end
    end

    assign tx_valid   = (r_state == S_SEND);
    assign busy       = (r_state == S_SEND) || (r_state == S_GAP);
    assign frame_done = (r_state == S_DONE);
    assign drop_count = r_drop;

endmodule
